// File: rtl/alu_arbiter_if.sv
// Handshake and datapath signals between two requesters, the arbiter and a shared ALU.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
  parameter int N = 32
);
  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [N-1:0] req0_x;
  logic [N-1:0] req0_y;
  logic [N-1:0] req1_x;
  logic [N-1:0] req1_y;
  logic [3:0]   req0_op;
  logic [3:0]   req1_op;
  logic [N-1:0] alu_x;
  logic [N-1:0] alu_y;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_z;
  logic         alu_zero;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic         rsp0_ready;
  logic         rsp1_ready;
  logic [N-1:0] rsp_z;
  logic         rsp_zero;

  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, req0_op, req1_op,
    input  alu_z, alu_zero, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_x, alu_y, alu_op,
    output rsp0_valid, rsp1_valid, rsp_z, rsp_zero
  );

  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, req0_op, req1_op,
    output alu_z, alu_zero, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_x, alu_y, alu_op,
    input  rsp0_valid, rsp1_valid, rsp_z, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation takes IDLE -> EXEC -> RESP, holding the result until the granted requester consumes it.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  state_t       state_next;
  logic         ptr;
  logic         gnt;
  logic         sel;
  logic         accept;
  logic         rsp_ready_g;
  logic [N-1:0] x_r;
  logic [N-1:0] y_r;
  logic [3:0]   op_r;
  logic [N-1:0] z_r;
  logic         zero_r;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) sel = ~ptr;
    else if (bus.req1_valid)              sel = 1'b1;
  end

  assign accept      = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
  assign rsp_ready_g = gnt ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready_g) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 1'b1;
      gnt    <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      op_r   <= '0;
      z_r    <= '0;
      zero_r <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        ptr  <= sel;
        gnt  <= sel;
        x_r  <= sel ? bus.req1_x  : bus.req0_x;
        y_r  <= sel ? bus.req1_y  : bus.req0_y;
        op_r <= sel ? bus.req1_op : bus.req0_op;
      end
      if (state == EXEC) begin
        z_r    <= bus.alu_z;
        zero_r <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready = accept && !sel;
  assign bus.req1_ready = accept &&  sel;
  assign bus.alu_x      = x_r;
  assign bus.alu_y      = y_r;
  assign bus.alu_op     = op_r;
  assign bus.rsp_z      = z_r;
  assign bus.rsp_zero   = zero_r;
  assign bus.rsp0_valid = (state == RESP) && !gnt;
  assign bus.rsp1_valid = (state == RESP) &&  gnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;

  localparam int N = 32;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd5;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_op)
      ALU_ADD: bus.alu_z = bus.alu_x + bus.alu_y;
      ALU_SUB: bus.alu_z = bus.alu_x - bus.alu_y;
      ALU_OR:  bus.alu_z = bus.alu_x | bus.alu_y;
      ALU_SLT: bus.alu_z = {{(N-1){1'b0}}, ($signed(bus.alu_x) < $signed(bus.alu_y))};
      default: bus.alu_z = '0;
    endcase
    bus.alu_zero = (bus.alu_z == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_op = '0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_op = '0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    tick(); tick();

    // Reset state, and no ready while reset is held even with a request pending
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_alu_x", bus.alu_x, 0);
    chk("rst_alu_y", bus.alu_y, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_rsp_z", bus.rsp_z, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    reset = 1'b0;
    tick();

    // Single op: ADD 5+7
    bus.req0_valid = 1; bus.req0_op = ALU_ADD; bus.req0_x = 5; bus.req0_y = 7;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1;
    chk("single_req0_ready", bus.req0_ready, 1);
    chk("single_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    chk("single_exec_rsp0_valid", bus.rsp0_valid, 0);
    chk("single_alu_x", bus.alu_x, 5);
    chk("single_alu_y", bus.alu_y, 7);
    chk("single_alu_op", bus.alu_op, ALU_ADD);
    tick();
    chk("single_rsp0_valid", bus.rsp0_valid, 1);
    chk("single_rsp1_valid", bus.rsp1_valid, 0);
    chk("single_rsp_z", bus.rsp_z, 12);
    chk("single_rsp_zero", bus.rsp_zero, 0);
    tick();
    chk("single_done_rsp0_valid", bus.rsp0_valid, 0);
    bus.req0_valid = 1;
    #1;
    chk("single_idle_ready", bus.req0_ready, 1);
    bus.req0_valid = 0;

    // Contention right after reset: req0 wins first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_valid = 1; bus.req0_op = ALU_SUB; bus.req0_x = 3; bus.req0_y = 3;
    bus.req1_valid = 1; bus.req1_op = ALU_OR;  bus.req1_x = 1; bus.req1_y = 2;
    #1;
    chk("cont_req0_ready", bus.req0_ready, 1);
    chk("cont_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    chk("cont_exec_req1_ready", bus.req1_ready, 0);
    tick();
    chk("cont_rsp0_valid", bus.rsp0_valid, 1);
    chk("cont_rsp1_valid_low", bus.rsp1_valid, 0);
    chk("cont_rsp_z0", bus.rsp_z, 0);
    chk("cont_rsp_zero0", bus.rsp_zero, 1);
    chk("cont_resp_req1_ready", bus.req1_ready, 0);
    tick();
    chk("cont_req1_ready_idle", bus.req1_ready, 1);
    tick(); tick();
    bus.req1_valid = 0;
    chk("cont_rsp1_valid", bus.rsp1_valid, 1);
    chk("cont_rsp0_valid_low", bus.rsp0_valid, 0);
    chk("cont_rsp_z1", bus.rsp_z, 3);
    chk("cont_rsp_zero1", bus.rsp_zero, 0);
    tick();

    // Fairness: last grant was req1, so req0 leads the alternation
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_op = ALU_ADD; bus.req1_op = ALU_ADD;
    bus.req0_y = 0; bus.req1_y = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req0_x = 32'(i); bus.req1_x = 32'(100 + i);
      #1;
      chk($sformatf("fair%0d_req0_ready", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("fair%0d_req1_ready", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick(); tick();
      chk($sformatf("fair%0d_rsp_valid", i), (i % 2 == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1);
      chk($sformatf("fair%0d_rsp_z", i), bus.rsp_z, (i % 2 == 0) ? i : 100 + i);
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();

    // Backpressure: SLT -1 < 1 held while rsp1_ready is low
    bus.rsp1_ready = 0; bus.rsp0_ready = 1;
    bus.req1_valid = 1; bus.req1_op = ALU_SLT; bus.req1_x = 32'hFFFF_FFFF; bus.req1_y = 1;
    #1;
    chk("bp_req1_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_op = ALU_ADD; bus.req0_x = 40; bus.req0_y = 2;
    #1;
    chk("bp_exec_req0_ready", bus.req0_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d_rsp1_valid", i), bus.rsp1_valid, 1);
      chk($sformatf("bp%0d_rsp_z", i), bus.rsp_z, 1);
      chk($sformatf("bp%0d_alu_x", i), bus.alu_x, 32'hFFFF_FFFF);
      chk($sformatf("bp%0d_alu_op", i), bus.alu_op, ALU_SLT);
      chk($sformatf("bp%0d_req0_ready", i), bus.req0_ready, 0);
      tick();
    end
    bus.rsp1_ready = 1;
    #1;
    chk("bp_release_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp_release_req0_ready", bus.req0_ready, 0);
    tick();
    chk("bp_resume_req0_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    tick();
    chk("bp_req0_rsp_z", bus.rsp_z, 42);
    chk("bp_req0_rsp0_valid", bus.rsp0_valid, 1);
    tick();

    // Stray ready from the non-granted requester is ignored
    bus.rsp1_ready = 0; bus.rsp0_ready = 1;
    bus.req1_valid = 1; bus.req1_op = ALU_OR; bus.req1_x = 8; bus.req1_y = 4;
    tick();
    bus.req1_valid = 0;
    tick();
    chk("stray_rsp1_valid", bus.rsp1_valid, 1);
    tick();
    chk("stray_rsp1_valid_held", bus.rsp1_valid, 1);
    chk("stray_rsp0_valid", bus.rsp0_valid, 0);
    chk("stray_rsp_z", bus.rsp_z, 12);
    bus.rsp1_ready = 1;
    tick();
    chk("stray_done_rsp1_valid", bus.rsp1_valid, 0);

    // Reset asserted while in EXEC aborts the operation
    bus.req0_valid = 1; bus.req0_op = ALU_ADD; bus.req0_x = 2; bus.req0_y = 3;
    tick();
    bus.req0_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rsp0_valid", bus.rsp0_valid, 0);
    chk("abort_rsp1_valid", bus.rsp1_valid, 0);
    chk("abort_alu_x", bus.alu_x, 0);
    chk("abort_alu_op", bus.alu_op, 0);
    chk("abort_rsp_z", bus.rsp_z, 0);
    tick();
    chk("abort_no_late_rsp", bus.rsp0_valid, 0);
    bus.req0_valid = 1;
    #1;
    chk("abort_regrant_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    tick();
    chk("abort_regrant_rsp0_valid", bus.rsp0_valid, 1);
    chk("abort_regrant_rsp_z", bus.rsp_z, 5);
    tick();

    // Undefined op code passes through; the ALU returns 0
    bus.req0_valid = 1; bus.req0_op = 4'hF; bus.req0_x = 5; bus.req0_y = 9;
    tick();
    bus.req0_valid = 0;
    chk("undef_alu_op", bus.alu_op, 4'hF);
    tick();
    chk("undef_rsp_z", bus.rsp_z, 0);
    chk("undef_rsp_zero", bus.rsp_zero, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
